// File: rtl/dbus_ctrl.sv
// Data-bus controller: decodes CPU data accesses into the data memory, a small
// timer/status MMIO window, or a bus error with first-error address capture.
module dbus_ctrl #(
    parameter logic [31:0] DMEM_BASE  = 32'h1001_0000,
    parameter int unsigned DMEM_WORDS = 2048,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        cpu_cs,
    input  logic        cpu_w,
    input  logic        cpu_r,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        dmem_we,
    output logic [10:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    output logic        irq
);

    localparam logic [31:0] DMEM_BYTES = 32'(DMEM_WORDS) << 2;

    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_CNT     = 3'd1;
    localparam logic [2:0] REG_CMP     = 3'd2;
    localparam logic [2:0] REG_STATUS  = 3'd3;
    localparam logic [2:0] REG_ERRADDR = 3'd4;

    logic        r_en;
    logic        r_ie;
    logic [31:0] r_cnt;
    logic [31:0] r_cmp;
    logic        r_match;
    logic        r_berr;
    logic [31:0] r_erraddr;

    logic        w_acc;
    logic        w_wr;
    logic        w_rd;
    logic        w_aligned;
    logic [31:0] w_dmem_off;
    logic        w_dmem_hit;
    logic        w_mmio_hit;
    logic        w_err;
    logic [2:0]  w_reg_sel;
    logic        w_mmio_wr;
    logic        w_wr_ctrl;
    logic        w_wr_cnt;
    logic        w_wr_cmp;
    logic        w_wr_status;
    logic        w_match_set;
    logic        w_match_clr;
    logic        w_berr_clr;
    logic [31:0] w_mmio_rdata;

    // A cycle with both strobes high is a write; reads are only pure reads.
    assign w_acc = cpu_cs & (cpu_r | cpu_w);
    assign w_wr  = cpu_cs & cpu_w;
    assign w_rd  = cpu_cs & cpu_r & ~cpu_w;

    assign w_aligned  = (cpu_addr[1:0] == 2'b00);
    assign w_dmem_off = cpu_addr - DMEM_BASE;
    assign w_dmem_hit = w_aligned & (cpu_addr >= DMEM_BASE) & (w_dmem_off < DMEM_BYTES);
    assign w_mmio_hit = w_aligned & (cpu_addr[31:5] == MMIO_BASE[31:5])
                      & (cpu_addr[4:0] < 5'h14);
    assign w_err      = w_acc & ~w_dmem_hit & ~w_mmio_hit;

    assign dmem_addr  = w_dmem_off[12:2];
    assign dmem_wdata = cpu_wdata;
    assign dmem_we    = w_wr & w_dmem_hit & ~reset;

    assign w_reg_sel   = cpu_addr[4:2];
    assign w_mmio_wr   = w_wr & w_mmio_hit;
    assign w_wr_ctrl   = w_mmio_wr & (w_reg_sel == REG_CTRL);
    assign w_wr_cnt    = w_mmio_wr & (w_reg_sel == REG_CNT);
    assign w_wr_cmp    = w_mmio_wr & (w_reg_sel == REG_CMP);
    assign w_wr_status = w_mmio_wr & (w_reg_sel == REG_STATUS);

    // Match compares the pre-edge counter against the pre-edge compare value.
    assign w_match_set = r_en & (r_cnt == r_cmp);
    assign w_match_clr = w_wr_status & cpu_wdata[0];
    assign w_berr_clr  = w_wr_status & cpu_wdata[1];

    assign irq = r_match & r_ie;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_en  <= 1'b0;
            r_ie  <= 1'b0;
            r_cmp <= 32'hFFFF_FFFF;
        end else begin
            if (w_wr_ctrl) begin
                r_en <= cpu_wdata[0];
                r_ie <= cpu_wdata[1];
            end
            if (w_wr_cmp) begin
                r_cmp <= cpu_wdata;
            end
        end
    end

    // A CPU write to CNT takes priority over the free-running increment.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_cnt <= 32'd0;
        end else if (w_wr_cnt) begin
            r_cnt <= cpu_wdata;
        end else if (r_en) begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

    // Status flags: a set event in the same cycle as a W1C clear wins.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_match   <= 1'b0;
            r_berr    <= 1'b0;
            r_erraddr <= 32'd0;
        end else begin
            r_match <= w_match_set | (r_match & ~w_match_clr);
            r_berr  <= w_err | (r_berr & ~w_berr_clr);
            if (w_err && !r_berr) begin
                r_erraddr <= cpu_addr;
            end
        end
    end

    always_comb begin
        w_mmio_rdata = 32'd0;
        case (w_reg_sel)
            REG_CTRL:    w_mmio_rdata = {30'd0, r_ie, r_en};
            REG_CNT:     w_mmio_rdata = r_cnt;
            REG_CMP:     w_mmio_rdata = r_cmp;
            REG_STATUS:  w_mmio_rdata = {30'd0, r_berr, r_match};
            REG_ERRADDR: w_mmio_rdata = r_erraddr;
            default:     w_mmio_rdata = 32'd0;
        endcase
    end

    always_comb begin
        cpu_rdata = 32'd0;
        if (w_rd && w_dmem_hit) begin
            cpu_rdata = dmem_rdata;
        end else if (w_rd && w_mmio_hit) begin
            cpu_rdata = w_mmio_rdata;
        end
    end

endmodule

// File: tb/tb_dbus_ctrl.sv
// Directed bench for dbus_ctrl: DMEM rebase, timer match/irq, wrap, set-wins,
// bus-error capture, reset mid-access and CNT write priority.
module tb_dbus_ctrl;

    localparam logic [31:0] A_CTRL = 32'hFFFF_0000;
    localparam logic [31:0] A_CNT  = 32'hFFFF_0004;
    localparam logic [31:0] A_CMP  = 32'hFFFF_0008;
    localparam logic [31:0] A_STAT = 32'hFFFF_000C;
    localparam logic [31:0] A_EADR = 32'hFFFF_0010;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        cpu_cs;
    logic        cpu_w;
    logic        cpu_r;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        dmem_we;
    logic [10:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        irq;

    logic [31:0] mem [0:2047];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        s_we;
    logic [10:0] s_addr;
    logic        s_irq;
    logic [31:0] v;

    dbus_ctrl dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .cpu_cs     (cpu_cs),
        .cpu_w      (cpu_w),
        .cpu_r      (cpu_r),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .irq        (irq)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        if (dmem_we) mem[dmem_addr] <= dmem_wdata;
    end
    assign dmem_rdata = mem[dmem_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        cpu_cs = 1'b0; cpu_w = 1'b0; cpu_r = 1'b0;
        cpu_addr = 32'd0; cpu_wdata = 32'd0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        cpu_cs = 1'b1; cpu_w = 1'b1; cpu_r = 1'b0; cpu_addr = a; cpu_wdata = d;
        #2;
        s_we = dmem_we; s_addr = dmem_addr; s_irq = irq;
        @(posedge clk_in); #1;
        idle();
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        cpu_cs = 1'b1; cpu_w = 1'b0; cpu_r = 1'b1; cpu_addr = a; cpu_wdata = 32'd0;
        #2;
        d = cpu_rdata; s_irq = irq;
        @(posedge clk_in); #1;
        idle();
    endtask

    task automatic chk_reset_state(input string pfx);
        rd(A_CTRL, v); chk({pfx, "_ctrl"}, v, 32'd0);
        rd(A_CNT,  v); chk({pfx, "_cnt"},  v, 32'd0);
        rd(A_CMP,  v); chk({pfx, "_cmp"},  v, 32'hFFFF_FFFF);
        rd(A_STAT, v); chk({pfx, "_stat"}, v, 32'd0);
        rd(A_EADR, v); chk({pfx, "_eadr"}, v, 32'd0);
        chk({pfx, "_irq"}, {31'd0, irq}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 32'd0;
        idle();
        reset = 1'b1;
        repeat (3) @(posedge clk_in);
        #1 reset = 1'b0;
        #2 chk("rst_rdata_idle", cpu_rdata, 32'd0);
        chk("rst_we", {31'd0, dmem_we}, 32'd0);
        chk_reset_state("rst");

        // 1. DMEM rebase
        wr(32'h1001_0008, 32'hDEAD_BEEF);
        chk("t1_we", {31'd0, s_we}, 32'd1);
        chk("t1_addr", {21'd0, s_addr}, 32'd2);
        rd(32'h1001_0008, v); chk("t1_rd", v, 32'hDEAD_BEEF);
        wr(32'h1001_2000, 32'h1234_5678);
        chk("t1_oob_we", {31'd0, s_we}, 32'd0);
        rd(A_STAT, v); chk("t1_berr", v, 32'd2);
        rd(A_EADR, v); chk("t1_eadr", v, 32'h1001_2000);
        wr(A_STAT, 32'd2);
        rd(A_STAT, v); chk("t1_clr", v, 32'd0);

        // 4. Bus error capture
        rd(32'h0000_0004, v); chk("t4_rd0", v, 32'd0);
        rd(A_STAT, v); chk("t4_berr", v, 32'd2);
        rd(A_EADR, v); chk("t4_eadr", v, 32'h0000_0004);
        wr(32'h1001_0003, 32'hAAAA_5555);
        chk("t4_mis_we", {31'd0, s_we}, 32'd0);
        rd(A_EADR, v); chk("t4_eadr_keep", v, 32'h0000_0004);
        wr(A_STAT, 32'd2);
        rd(32'h2000_0000, v); chk("t4_rd1", v, 32'd0);
        rd(A_EADR, v); chk("t4_eadr2", v, 32'h2000_0000);
        wr(A_STAT, 32'd2);
        rd(32'hFFFF_0014, v); chk("t4_off14_rd", v, 32'd0);
        rd(A_STAT, v); chk("t4_off14_berr", v, 32'd2);
        rd(A_EADR, v); chk("t4_off14_eadr", v, 32'hFFFF_0014);
        wr(A_STAT, 32'd2);
        wr(A_EADR, 32'h5555_5555);
        rd(A_EADR, v); chk("t4_eadr_ro", v, 32'hFFFF_0014);
        rd(A_STAT, v); chk("t4_stat0", v, 32'd0);

        // 2. Timer match and irq
        wr(A_CMP, 32'd10);
        wr(A_CNT, 32'd0);
        wr(A_CTRL, 32'd3);
        for (int k = 0; k < 14; k++) begin
            rd(A_CNT, v);
            chk($sformatf("t2_cnt%0d", k), v, 32'(k));
            chk($sformatf("t2_irq%0d", k), {31'd0, s_irq}, (k >= 11) ? 32'd1 : 32'd0);
        end
        wr(A_STAT, 32'd1);
        rd(A_CNT, v); chk("t2_cnt_run", v, 32'd15);
        chk("t2_irq_clr", {31'd0, s_irq}, 32'd0);

        // 3. Wrap and set-wins
        wr(A_CTRL, 32'd1);
        wr(A_CMP, 32'd0);
        wr(A_STAT, 32'd1);
        wr(A_CNT, 32'hFFFF_FFFE);
        rd(A_CNT, v); chk("t3_cnt_fe", v, 32'hFFFF_FFFE);
        rd(A_STAT, v); chk("t3_nomatch", v, 32'd0);
        wr(A_STAT, 32'd1);
        rd(A_STAT, v); chk("t3_setwins", v, 32'd1);
        rd(A_CNT, v); chk("t3_wrapped", v, 32'd2);
        wr(A_STAT, 32'd1);
        rd(A_STAT, v); chk("t3_clr", v, 32'd0);

        // 6. CNT write priority over increment
        wr(A_CNT, 32'd100);
        rd(A_CNT, v); chk("t6_cnt100", v, 32'd100);
        rd(A_CNT, v); chk("t6_cnt101", v, 32'd101);
        wr(A_CTRL, 32'hFFFF_FFFF);
        rd(A_CTRL, v); chk("t6_ctrl_mask", v, 32'd3);

        // 5. Reset mid-operation
        wr(A_CMP, 32'd5);
        cpu_cs = 1'b1; cpu_w = 1'b1; cpu_r = 1'b0;
        cpu_addr = A_CNT; cpu_wdata = 32'd77;
        reset = 1'b1;
        @(posedge clk_in); #1;
        reset = 1'b0; idle();
        chk_reset_state("t5");
        cpu_cs = 1'b1; cpu_w = 1'b1; cpu_r = 1'b0;
        cpu_addr = 32'h1001_0010; cpu_wdata = 32'h1234_5678;
        reset = 1'b1;
        #2 chk("t5_rst_we", {31'd0, dmem_we}, 32'd0);
        @(posedge clk_in); #1;
        reset = 1'b0; idle();
        rd(32'h1001_0010, v); chk("t5_dropped", v, 32'd0);
        rd(32'h1001_0008, v); chk("t5_mem_kept", v, 32'hDEAD_BEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
